// File: rtl/kim_scan_pkg.sv
// Shared types and default geometry for the keypad/LED scan engine.
package kim_scan_pkg;

  localparam int unsigned NUM_ROWS_DEF   = 4;
  localparam int unsigned NUM_DIGITS_DEF = 6;
  localparam int unsigned NUM_COLS_DEF   = 7;

  localparam int unsigned NUM_SEL = NUM_ROWS_DEF + NUM_DIGITS_DEF;
  localparam int unsigned SEL_W   = $clog2(NUM_SEL);
  localparam int unsigned CODE_W  = $clog2(NUM_ROWS_DEF * NUM_COLS_DEF);

  typedef enum logic [1:0] {
    KeyIdle,
    KeyPressDb,
    KeyHeld,
    KeyRelDb
  } key_state_e;

  typedef enum logic {
    PhActive,
    PhBlank
  } phase_e;

endpackage

// File: rtl/kim_key_debounce.sv
// Per-scan key debounce FSM with a one-entry handshaked key-code holding register.
module kim_key_debounce
  import kim_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CodeW    = CODE_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             eval_i,
  input  logic             cand_vld_i,
  input  logic [CodeW-1:0] cand_code_i,
  input  logic             key_ready_i,
  output logic             key_valid_o,
  output logic [CodeW-1:0] key_code_o,
  output logic             key_held_o,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] DbCnt = CntW'(DEBOUNCE);
  localparam bit DbOne = (DEBOUNCE == 1);

  key_state_e       st_q, st_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CodeW-1:0] ref_q, ref_d;
  logic             key_valid_q, key_valid_d;
  logic [CodeW-1:0] key_code_q, key_code_d;
  logic             key_held_q, key_held_d;
  logic             overrun_q, overrun_d;
  logic             emit, take;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ref_d = ref_q;
    emit  = 1'b0;
    if (eval_i) begin
      unique case (st_q)
        KeyIdle: begin
          if (cand_vld_i) begin
            ref_d = cand_code_i;
            cnt_d = CntW'(1);
            if (DbOne) begin
              st_d = KeyHeld;
              emit = 1'b1;
            end else begin
              st_d = KeyPressDb;
            end
          end
        end
        KeyPressDb: begin
          if (cand_vld_i && (cand_code_i == ref_q)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DbCnt) begin
              st_d = KeyHeld;
              emit = 1'b1;
            end
          end else begin
            st_d = KeyIdle;
          end
        end
        KeyHeld: begin
          // Any key keeps us here; only a full release starts release debounce.
          if (!cand_vld_i) begin
            cnt_d = CntW'(1);
            st_d  = DbOne ? KeyIdle : KeyRelDb;
          end
        end
        KeyRelDb: begin
          if (cand_vld_i) begin
            st_d = KeyHeld;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DbCnt) st_d = KeyIdle;
          end
        end
        default: st_d = KeyIdle;
      endcase
    end
  end

  always_comb begin
    take        = key_valid_q & key_ready_i;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    if (take) key_valid_d = 1'b0;
    if (emit) begin
      if (key_valid_q && !take) begin
        overrun_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = ref_d;
      end
    end
    key_held_d = (st_d == KeyHeld) || (st_d == KeyRelDb);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= KeyIdle;
      cnt_q       <= '0;
      ref_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_held_o  = key_held_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/kim_scan_ctrl.sv
// Keypad/LED scan engine: slot timer, segment RAM, per-scan key candidate capture.
module kim_scan_ctrl
  import kim_scan_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = NUM_ROWS_DEF,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned NUM_COLS   = NUM_COLS_DEF,
  parameter int unsigned DWELL      = 1000,
  parameter int unsigned BLANK      = 16,
  parameter int unsigned DEBOUNCE   = 4,
  localparam int unsigned SelN  = NUM_ROWS + NUM_DIGITS,
  localparam int unsigned AddrW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CodeW = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [SelN-1:0]     sel_n,
  output logic [NUM_COLS-1:0] seg_n,
  input  logic [NUM_COLS-1:0] col_n,
  input  logic                wr_en,
  input  logic [AddrW-1:0]    wr_addr,
  input  logic [NUM_COLS-1:0] wr_data,
  output logic                key_valid,
  output logic [CodeW-1:0]    key_code,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);

  localparam int unsigned SelW    = (SelN > 1) ? $clog2(SelN) : 1;
  localparam int unsigned TmrMax  = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TmrW    = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0]  DwellLast = TmrW'(DWELL - 1);
  localparam logic [TmrW-1:0]  BlankLast = TmrW'(BLANK - 1);
  localparam logic [SelW-1:0]  SlotLast  = SelW'(SelN - 1);
  localparam logic [SelW-1:0]  RowsN     = SelW'(NUM_ROWS);
  localparam logic [AddrW:0]   AddrLim   = (AddrW + 1)'(NUM_DIGITS);

  phase_e              phase_q, phase_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [SelW-1:0]     slot_q, slot_d;
  logic [NUM_COLS-1:0] segram_q [NUM_DIGITS];
  logic [NUM_COLS-1:0] segram_d [NUM_DIGITS];
  logic [SelN-1:0]     sel_n_q, sel_n_d;
  logic [NUM_COLS-1:0] seg_n_q, seg_n_d;
  logic                cand_vld_q, cand_vld_d;
  logic [CodeW-1:0]    cand_code_q, cand_code_d;
  logic [AddrW-1:0]    dig_idx;
  logic                scan_end, row_sample, row_hit;

  always_comb begin
    phase_d  = phase_q;
    tmr_d    = tmr_q + 1'b1;
    slot_d   = slot_q;
    scan_end = 1'b0;
    if (phase_q == PhActive) begin
      if (tmr_q == DwellLast) begin
        phase_d = PhBlank;
        tmr_d   = '0;
      end
    end else if (tmr_q == BlankLast) begin
      phase_d = PhActive;
      tmr_d   = '0;
      if (slot_q == SlotLast) begin
        slot_d   = '0;
        scan_end = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_comb begin
    segram_d = segram_q;
    if (wr_en && ({1'b0, wr_addr} < AddrLim)) segram_d[wr_addr] = wr_data;
  end

  // Outputs are registered from current slot state, so the pins lag the timer by one clock;
  // the write path uses segram_d so a write to the shown digit appears on the next clock.
  always_comb begin
    dig_idx = AddrW'(slot_q - RowsN);
    sel_n_d = '1;
    seg_n_d = '1;
    if (phase_q == PhActive) begin
      sel_n_d[slot_q] = 1'b0;
      if (slot_q >= RowsN) seg_n_d = ~segram_d[dig_idx];
    end
  end

  // First BLANK timer clock is the last clock the row select is visible on the pins.
  assign row_sample = (phase_q == PhBlank) && (tmr_q == '0) && (slot_q < RowsN);

  always_comb begin
    cand_vld_d  = cand_vld_q;
    cand_code_d = cand_code_q;
    row_hit     = 1'b0;
    if (row_sample && !cand_vld_q) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (!col_n[c] && !row_hit) begin
          row_hit     = 1'b1;
          cand_vld_d  = 1'b1;
          cand_code_d = CodeW'(32'(slot_q) * NUM_COLS + c);
        end
      end
    end
    if (scan_end) cand_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= PhActive;
      tmr_q       <= '0;
      slot_q      <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) segram_q[i] <= '0;
      sel_n_q     <= '1;
      seg_n_q     <= '1;
      cand_vld_q  <= 1'b0;
      cand_code_q <= '0;
    end else begin
      phase_q     <= phase_d;
      tmr_q       <= tmr_d;
      slot_q      <= slot_d;
      segram_q    <= segram_d;
      sel_n_q     <= sel_n_d;
      seg_n_q     <= seg_n_d;
      cand_vld_q  <= cand_vld_d;
      cand_code_q <= cand_code_d;
    end
  end

  assign sel_n = sel_n_q;
  assign seg_n = seg_n_q;

  kim_key_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CodeW    (CodeW)
  ) u_key_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .eval_i      (scan_end),
    .cand_vld_i  (cand_vld_q),
    .cand_code_i (cand_code_q),
    .key_ready_i (key_ready),
    .key_valid_o (key_valid),
    .key_code_o  (key_code),
    .key_held_o  (key_held),
    .overrun_o   (overrun)
  );

endmodule
